// File: rtl/i2c_sensor_poller.sv
// Polls one sensor register over an I2C master: writes the pointer, then reads NUM_BYTES into a right-aligned sample.
// Latency: request -> m_start 2 cycles, write m_done -> read m_start 3 cycles, read m_done -> sample_valid 2 cycles.
// Backpressure: none; requests arriving while busy are dropped, and a stalled master is abandoned after TIMEOUT_CYCLES.
module i2c_sensor_poller #(
    parameter int          CLK_FREQ       = 12_000_000,
    parameter int          POLL_HZ        = 10,
    parameter logic [6:0]  DEV_ADDR       = 7'h48,
    parameter logic [7:0]  REG_PTR        = 8'h00,
    parameter int          NUM_BYTES      = 2,
    parameter int          TIMEOUT_CYCLES = 24_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    output logic        m_start,
    output logic [6:0]  m_slave_addr,
    output logic        m_rw,
    output logic [7:0]  m_data_in,
    output logic        m_ack_master,
    input  logic [7:0]  m_data_slave,
    input  logic        m_reg_ready,
    input  logic        m_done,
    output logic [31:0] sample,
    output logic        sample_valid,
    output logic        nack_err,
    output logic        timeout_err,
    output logic        busy
);

    localparam int              POLL_DIV   = CLK_FREQ / POLL_HZ;
    localparam int              PW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0]   POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      NB         = 8'(NUM_BYTES);
    // Read expects an address ACK slot plus one slot per data byte.
    localparam logic [7:0]      RD_PULSES  = 8'(NUM_BYTES + 1);
    localparam logic            ACK_AT_RS  = (NUM_BYTES == 1);

    typedef enum logic [2:0] {
        IDLE, W_START, W_WAIT, GAP, R_START, R_WAIT, FINISH
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_poll;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_rcnt;
    logic [31:0]     r_shreg;
    logic            w_tick;
    logic [7:0]      w_rcnt_nxt;

    assign m_slave_addr = DEV_ADDR;
    assign m_data_in    = REG_PTR;
    assign w_tick       = enable && (r_poll == POLL_LAST);
    // Includes a pulse landing in the same cycle as m_done so it is not lost from the count.
    assign w_rcnt_nxt   = r_rcnt + {7'd0, m_reg_ready};

    // Poll divider: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_poll <= '0;
        end else if (!enable || (r_poll == POLL_LAST)) begin
            r_poll <= '0;
        end else begin
            r_poll <= r_poll + PW'(1);
        end
    end

    // Sequencer: write pointer, gap, read bytes, publish; all outputs registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_tcnt       <= '0;
            r_rcnt       <= '0;
            r_shreg      <= '0;
            m_start      <= 1'b0;
            m_rw         <= 1'b0;
            m_ack_master <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            nack_err     <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            m_start      <= 1'b0;
            sample_valid <= 1'b0;
            nack_err     <= 1'b0;
            timeout_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy <= 1'b0;
                    if (trigger || w_tick) begin
                        r_state <= W_START;
                        busy    <= 1'b1;
                    end
                end
                W_START: begin
                    m_start      <= 1'b1;
                    m_rw         <= 1'b0;
                    m_ack_master <= 1'b0;
                    r_rcnt       <= '0;
                    r_tcnt       <= '0;
                    r_shreg      <= '0;
                    r_state      <= W_WAIT;
                end
                W_WAIT: begin
                    r_rcnt <= w_rcnt_nxt;
                    if (m_done) begin
                        // Address ACK plus pointer ACK means the write landed.
                        if (w_rcnt_nxt == 8'd2) begin
                            r_state <= GAP;
                        end else begin
                            nack_err <= 1'b1;
                            r_state  <= IDLE;
                            busy     <= 1'b0;
                        end
                    end else if (r_tcnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                GAP: begin
                    r_state <= R_START;
                end
                R_START: begin
                    m_start      <= 1'b1;
                    m_rw         <= 1'b1;
                    m_ack_master <= ACK_AT_RS;
                    r_rcnt       <= '0;
                    r_tcnt       <= '0;
                    r_state      <= R_WAIT;
                end
                R_WAIT: begin
                    if (m_reg_ready) begin
                        // First slot is the address ACK and carries no data.
                        if (r_rcnt != 8'd0) begin
                            r_shreg <= {r_shreg[23:0], m_data_slave};
                        end
                        r_rcnt       <= w_rcnt_nxt;
                        m_ack_master <= (w_rcnt_nxt >= NB);
                    end
                    if (m_done) begin
                        if (w_rcnt_nxt == RD_PULSES) begin
                            r_state <= FINISH;
                        end else begin
                            nack_err <= 1'b1;
                            r_state  <= IDLE;
                            busy     <= 1'b0;
                        end
                    end else if (r_tcnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    sample       <= r_shreg;
                    sample_valid <= 1'b1;
                    r_state      <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
